// File: rtl/vx_local_mem_ctrl_pkg.sv
// Shared types for the local memory request scheduler: FSM states, default
// bus widths and the queued request record.
package vx_local_mem_ctrl_pkg;

  localparam int unsigned VX_DATA_W = 32;
  localparam int unsigned VX_ADDR_W = 26;
  localparam int unsigned VX_TAG_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // Request record at the default bus widths; the controller builds the same
  // layout from its own parameters and hands it to the FIFO as a type.
  typedef struct packed {
    logic                   rw;
    logic [VX_DATA_W/8-1:0] byteen;
    logic [VX_ADDR_W-1:0]   addr;
    logic [VX_DATA_W-1:0]   data;
    logic [VX_TAG_W-1:0]    tag;
  } mem_req_t;

endpackage

// File: rtl/vx_local_mem_ctrl_if.sv
// Vortex-side memory bus: request channel in, read-response channel out.
interface vx_local_mem_ctrl_if #(
  parameter int unsigned DATA_W   = vx_local_mem_ctrl_pkg::VX_DATA_W,
  parameter int unsigned ADDR_W   = vx_local_mem_ctrl_pkg::VX_ADDR_W,
  parameter int unsigned TAG_W    = vx_local_mem_ctrl_pkg::VX_TAG_W,
  parameter int unsigned BYTEEN_W = DATA_W / 8
) ();

  logic                mem_req_valid;
  logic                mem_req_rw;
  logic [BYTEEN_W-1:0] mem_req_byteen;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic [DATA_W-1:0]   mem_req_data;
  logic [TAG_W-1:0]    mem_req_tag;
  logic                mem_req_ready;

  logic                mem_rsp_valid;
  logic [DATA_W-1:0]   mem_rsp_data;
  logic [TAG_W-1:0]    mem_rsp_tag;
  logic                mem_rsp_err;
  logic                mem_rsp_ready;

  // Vortex side
  modport master (
    output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
           mem_req_data, mem_req_tag, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag, mem_rsp_err
  );

  // Controller side
  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
           mem_req_data, mem_req_tag, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag, mem_rsp_err
  );

endinterface

// File: rtl/vx_req_fifo.sv
// Synchronous in-order request queue. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate occupancy counter.
module vx_req_fifo
  import vx_local_mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = mem_req_t
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t pop_data,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      store_q [DEPTH];

  logic do_push;
  logic do_pop;

  // Status flags and head-of-queue read port
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    pop_data = store_q[rd_ptr[AW-1:0]];
  end

  // Pointer update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (do_push) store_q[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/vx_local_mem_ctrl.sv
// Request scheduler between the Vortex memory port and the local_mem model:
// queues requests, issues them one at a time, returns read data after a fixed
// latency with the original tag, honouring response backpressure.
module vx_local_mem_ctrl
  import vx_local_mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = VX_DATA_W,
  parameter int unsigned ADDR_W    = VX_ADDR_W,
  parameter int unsigned TAG_W     = VX_TAG_W,
  parameter int unsigned BYTEEN_W  = DATA_W / 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned RSP_DELAY = 15,
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  vx_local_mem_ctrl_if.slave  mem_bus,
  output logic                lm_req_valid,
  output logic                lm_req_rw,
  output logic [BYTEEN_W-1:0] lm_req_byteen,
  output logic [ADDR_W-1:0]   lm_req_addr,
  output logic [DATA_W-1:0]   lm_req_data,
  input  logic [DATA_W-1:0]   lm_rd_data,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(RSP_DELAY + 1);
  localparam logic [CNT_W-1:0]  CNT_FIRST  = CNT_W'(RSP_DELAY - 1);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

  typedef struct packed {
    logic                rw;
    logic [BYTEEN_W-1:0] byteen;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [TAG_W-1:0]    tag;
  } req_t;

  state_t            state;
  state_t            state_nxt;
  req_t              push_req;
  req_t              head;
  req_t              hold_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              in_bounds;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic              rsp_err_q;

  // Pack the incoming bus request into a queue entry
  always_comb begin
    push_req        = '0;
    push_req.rw     = mem_bus.mem_req_rw;
    push_req.byteen = mem_bus.mem_req_byteen;
    push_req.addr   = mem_bus.mem_req_addr;
    push_req.data   = mem_bus.mem_req_data;
    push_req.tag    = mem_bus.mem_req_tag;
  end

  vx_req_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (req_t)
  ) u_req_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (mem_bus.mem_req_valid),
    .push_data (push_req),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state and queue pop
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = hold_q.rw ? IDLE : WAIT;
      WAIT:  if (cnt_q == '0) state_nxt = RESP;
      RESP:  if (mem_bus.mem_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Holding register, delay counter and response capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q     <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (pop) hold_q <= head;
      case (state)
        ISSUE: if (!hold_q.rw) cnt_q <= CNT_FIRST;
        WAIT: begin
          // Counter still at its load value marks the cycle local_mem returns data
          if (cnt_q == CNT_FIRST) begin
            rsp_data_q <= in_bounds ? lm_rd_data : '0;
            rsp_tag_q  <= hold_q.tag;
            rsp_err_q  <= !in_bounds;
          end
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output decode: local_mem command, response channel, status
  always_comb begin
    in_bounds     = ({1'b0, hold_q.addr} < ADDR_LIMIT);
    lm_req_valid  = (state == ISSUE) && in_bounds;
    lm_req_rw     = hold_q.rw;
    lm_req_byteen = hold_q.byteen;
    lm_req_addr   = hold_q.addr;
    lm_req_data   = hold_q.data;
    busy          = !fifo_empty || (state != IDLE);
  end

  assign mem_bus.mem_req_ready = !fifo_full;
  assign mem_bus.mem_rsp_valid = (state == RESP);
  assign mem_bus.mem_rsp_data  = rsp_data_q;
  assign mem_bus.mem_rsp_tag   = rsp_tag_q;
  assign mem_bus.mem_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_vx_local_mem_ctrl.sv
// Bench for vx_local_mem_ctrl: directed latency/backpressure/bounds/reset
// steps followed by random traffic, checked against a word-level memory model.
module tb_vx_local_mem_ctrl;

  localparam int unsigned DW = 32, AW = 16, TW = 8, BW = 4;
  localparam int unsigned DEPTH = 4, DELAY = 15, WORDS = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vx_local_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW), .TAG_W(TW), .BYTEEN_W(BW)) bus ();
  vx_local_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW), .TAG_W(TW), .BYTEEN_W(BW)) bus2 ();

  logic          lm_req_valid, lm_req_rw, busy;
  logic [BW-1:0] lm_req_byteen;
  logic [AW-1:0] lm_req_addr;
  logic [DW-1:0] lm_req_data, lm_rd_data;
  logic          lm2_valid, lm2_rw, busy2;
  logic [BW-1:0] lm2_byteen;
  logic [AW-1:0] lm2_addr;
  logic [DW-1:0] lm2_data, lm2_rd_data;

  vx_local_mem_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .TAG_W(TW), .BYTEEN_W(BW),
    .DEPTH(DEPTH), .RSP_DELAY(DELAY), .MEM_WORDS(WORDS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mem_bus(bus),
    .lm_req_valid(lm_req_valid), .lm_req_rw(lm_req_rw), .lm_req_byteen(lm_req_byteen),
    .lm_req_addr(lm_req_addr), .lm_req_data(lm_req_data), .lm_rd_data(lm_rd_data),
    .busy(busy)
  );

  vx_local_mem_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .TAG_W(TW), .BYTEEN_W(BW),
    .DEPTH(DEPTH), .RSP_DELAY(1), .MEM_WORDS(WORDS)
  ) dut_fast (
    .clk(clk), .reset_n(reset_n), .mem_bus(bus2),
    .lm_req_valid(lm2_valid), .lm_req_rw(lm2_rw), .lm_req_byteen(lm2_byteen),
    .lm_req_addr(lm2_addr), .lm_req_data(lm2_data), .lm_rd_data(lm2_rd_data),
    .busy(busy2)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // local_mem stand-ins: read data is valid only the cycle after a read, garbage otherwise
  logic [31:0] lmem [64];
  logic [31:0] lmem2 [64];
  always @(posedge clk) begin
    lm_rd_data <= $urandom();
    if (lm_req_valid) begin
      if (lm_req_rw) lmem[lm_req_addr[5:0]] <= merge(lmem[lm_req_addr[5:0]], lm_req_data, lm_req_byteen);
      else           lm_rd_data <= lmem[lm_req_addr[5:0]];
    end
  end
  always @(posedge clk) begin
    lm2_rd_data <= $urandom();
    if (lm2_valid) begin
      if (lm2_rw) lmem2[lm2_addr[5:0]] <= merge(lmem2[lm2_addr[5:0]], lm2_data, lm2_byteen);
      else        lm2_rd_data <= lmem2[lm2_addr[5:0]];
    end
  end

  // Reference model: memory image updated at acceptance, expected command and response queues
  typedef struct { logic rw; logic [3:0] be; logic [15:0] addr; logic [31:0] data; } lm_cmd_t;
  typedef struct { logic [31:0] data; logic [7:0] tag; logic err; } rsp_t;
  logic [31:0] ref_mem [64];
  logic [31:0] ref_save [64];
  lm_cmd_t lm_exp[$];
  rsp_t    rsp_exp[$];

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int lm_count = 0;
  int last_release = -100;
  bit rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic model_accept(input logic rw, input logic [15:0] addr, input logic [31:0] data,
                              input logic [3:0] be, input logic [7:0] tag);
    lm_cmd_t c;
    rsp_t    r;
    bit ib;
    ib = (addr < 16'(WORDS));
    c.rw = rw; c.be = be; c.addr = addr; c.data = data;
    if (rw) begin
      if (ib) begin
        ref_mem[addr[5:0]] = merge(ref_mem[addr[5:0]], data, be);
        lm_exp.push_back(c);
      end
    end else begin
      r.data = ib ? ref_mem[addr[5:0]] : 32'h0;
      r.tag  = tag;
      r.err  = !ib;
      rsp_exp.push_back(r);
      if (ib) lm_exp.push_back(c);
    end
  endtask

  task automatic send(input logic rw, input logic [15:0] addr, input logic [31:0] data,
                      input logic [3:0] be, input logic [7:0] tag, output int acc);
    int g;
    g = 0;
    bus.mem_req_valid = 1'b1; bus.mem_req_rw = rw; bus.mem_req_addr = addr;
    bus.mem_req_data = data; bus.mem_req_byteen = be; bus.mem_req_tag = tag;
    while (!bus.mem_req_ready && g < 300) begin step(); g++; end
    check("req_accept", 64'(bus.mem_req_ready), 64'd1);
    acc = int'(cyc);
    model_accept(rw, addr, data, be, tag);
    step();
    bus.mem_req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int g;
    g = 0;
    while (!bus.mem_rsp_valid && g < bound) begin step(); g++; end
    check(tag, 64'(bus.mem_rsp_valid), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int g;
    g = 0;
    while (busy && g < bound) begin step(); g++; end
    check(tag, 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 64'(bus.mem_req_ready), 64'd1);
    check("rst_rsp_valid", 64'(bus.mem_rsp_valid), 64'd0);
    check("rst_rsp_data",  64'(bus.mem_rsp_data),  64'd0);
    check("rst_rsp_tag",   64'(bus.mem_rsp_tag),   64'd0);
    check("rst_rsp_err",   64'(bus.mem_rsp_err),   64'd0);
    check("rst_lm_valid",  64'(lm_req_valid),      64'd0);
    check("rst_busy",      64'(busy),              64'd0);
  endtask

  // Monitor: command order/content, response content, hold stability, issue spacing
  logic       prev_valid = 1'b0, prev_hs = 1'b0, prev_err = 1'b0;
  logic [31:0] prev_data = '0;
  logic [7:0]  prev_tag = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
      last_release = -100;
    end else begin
      if (lm_req_valid) begin
        lm_count++;
        check("issue_gap", 64'((int'(cyc) - last_release) >= 2), 64'd1);
        check("lm_expected", 64'(lm_exp.size() != 0), 64'd1);
        if (lm_exp.size() != 0) begin
          lm_cmd_t e;
          e = lm_exp.pop_front();
          check("lm_rw", 64'(lm_req_rw), 64'(e.rw));
          check("lm_addr", 64'(lm_req_addr), 64'(e.addr));
          if (e.rw) begin
            check("lm_data", 64'(lm_req_data), 64'(e.data));
            check("lm_byteen", 64'(lm_req_byteen), 64'(e.be));
          end
        end
        if (lm_req_rw) last_release = int'(cyc);
      end
      if (bus.mem_rsp_valid) begin
        if (prev_valid && !prev_hs) begin
          check("hold_data", 64'(bus.mem_rsp_data), 64'(prev_data));
          check("hold_tag",  64'(bus.mem_rsp_tag),  64'(prev_tag));
          check("hold_err",  64'(bus.mem_rsp_err),  64'(prev_err));
        end
        if (bus.mem_rsp_ready) begin
          check("rsp_expected", 64'(rsp_exp.size() != 0), 64'd1);
          if (rsp_exp.size() != 0) begin
            rsp_t r;
            r = rsp_exp.pop_front();
            check("rsp_data", 64'(bus.mem_rsp_data), 64'(r.data));
            check("rsp_tag",  64'(bus.mem_rsp_tag),  64'(r.tag));
            check("rsp_err",  64'(bus.mem_rsp_err),  64'(r.err));
          end
          hs_count++;
          last_release = int'(cyc);
        end
      end
      prev_valid = bus.mem_rsp_valid;
      prev_hs    = bus.mem_rsp_valid && bus.mem_rsp_ready;
      prev_data  = bus.mem_rsp_data;
      prev_tag   = bus.mem_rsp_tag;
      prev_err   = bus.mem_rsp_err;
    end
  end

  // Random response backpressure during the random phase
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) bus.mem_rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int acc, hs0, lmc0, h, seen;
    logic [31:0] d0;
    logic [7:0]  t0;

    for (int i = 0; i < 64; i++) begin lmem[i] = '0; lmem2[i] = '0; ref_mem[i] = '0; end
    bus.mem_req_valid = 0; bus.mem_req_rw = 0; bus.mem_req_addr = '0; bus.mem_req_data = '0;
    bus.mem_req_byteen = '0; bus.mem_req_tag = '0; bus.mem_rsp_ready = 1'b1;
    bus2.mem_req_valid = 0; bus2.mem_req_rw = 0; bus2.mem_req_addr = '0; bus2.mem_req_data = '0;
    bus2.mem_req_byteen = '0; bus2.mem_req_tag = '0; bus2.mem_rsp_ready = 1'b1;

    // Reset state
    step(3);
    check_reset_outputs();
    reset_n = 1'b1;
    step(2);

    // Write 0xDEADBEEF to addr 5, then read it back
    send(1'b1, 16'd5, 32'hDEADBEEF, 4'hF, 8'h01, acc);
    check("wr_busy", 64'(busy), 64'd1);
    step();
    check("wr_issue_c2", 64'(lm_req_valid), 64'd1);
    check("wr_issue_addr", 64'(lm_req_addr), 64'd5);
    step();
    check("wr_idle_c3_lm", 64'(lm_req_valid), 64'd0);
    check("wr_idle_c3_busy", 64'(busy), 64'd0);

    send(1'b0, 16'd5, 32'h0, 4'hF, 8'h3C, acc);
    wait_valid("rd_rsp_seen", 100);
    check("rd_latency", 64'(int'(cyc) - acc), 64'(DELAY + 3));
    check("rd_data", 64'(bus.mem_rsp_data), 64'h0DEADBEEF);
    check("rd_tag", 64'(bus.mem_rsp_tag), 64'h3C);
    check("rd_err", 64'(bus.mem_rsp_err), 64'd0);
    step();
    wait_idle("rd_idle", 50);

    // Five writes while a read occupies the FSM: queue fills after the 4th
    send(1'b0, 16'd10, 32'h0, 4'hF, 8'h10, acc);
    for (int i = 0; i < 4; i++) send(1'b1, 16'(i), $urandom(), 4'hF, 8'(i), acc);
    check("full_ready_low", 64'(bus.mem_req_ready), 64'd0);
    send(1'b1, 16'd4, $urandom(), 4'hF, 8'h04, acc);
    wait_idle("five_idle", 400);
    check("five_lm_drained", 64'(lm_exp.size()), 64'd0);

    // Response backpressure for 10 cycles with a write queued behind
    bus.mem_rsp_ready = 1'b0;
    send(1'b0, 16'd5, 32'h0, 4'hF, 8'h77, acc);
    send(1'b1, 16'd7, 32'hCAFE0007, 4'hF, 8'h78, acc);
    wait_valid("bp_rsp_seen", 100);
    d0 = bus.mem_rsp_data;
    t0 = bus.mem_rsp_tag;
    check("bp_data", 64'(d0), 64'h0DEADBEEF);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_held", 64'(bus.mem_rsp_valid), 64'd1);
      check("bp_data_held", 64'(bus.mem_rsp_data), 64'(d0));
      check("bp_tag_held", 64'(bus.mem_rsp_tag), 64'(t0));
      step();
    end
    hs0 = hs_count;
    h = int'(cyc);
    bus.mem_rsp_ready = 1'b1;
    step();
    check("bp_valid_drop", 64'(bus.mem_rsp_valid), 64'd0);
    check("bp_no_issue_h1", 64'(lm_req_valid), 64'd0);
    step();
    check("bp_issue_h2", 64'(lm_req_valid), 64'd1);
    check("bp_issue_cyc", 64'(int'(cyc) - h), 64'd2);
    check("bp_issue_addr", 64'(lm_req_addr), 64'd7);
    check("bp_single_hs", 64'(hs_count - hs0), 64'd1);
    wait_idle("bp_idle", 50);

    // Out-of-bounds read and write
    lmc0 = lm_count;
    send(1'b0, 16'd64, 32'h0, 4'hF, 8'h55, acc);
    wait_valid("oob_rsp_seen", 100);
    check("oob_latency", 64'(int'(cyc) - acc), 64'(DELAY + 3));
    check("oob_data", 64'(bus.mem_rsp_data), 64'd0);
    check("oob_err", 64'(bus.mem_rsp_err), 64'd1);
    check("oob_tag", 64'(bus.mem_rsp_tag), 64'h55);
    step();
    wait_idle("oob_rd_idle", 50);
    send(1'b1, 16'd70, 32'h12345678, 4'hF, 8'h56, acc);
    wait_idle("oob_wr_idle", 50);
    step(2);
    check("oob_no_lm", 64'(lm_count - lmc0), 64'd0);

    // Reset during WAIT with two requests queued
    ref_save = ref_mem;
    send(1'b0, 16'd1, 32'h0, 4'hF, 8'h21, acc);
    send(1'b1, 16'd2, 32'h22222222, 4'hF, 8'h22, acc);
    send(1'b1, 16'd3, 32'h33333333, 4'hF, 8'h23, acc);
    step(2);
    check("pre_rst_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    lm_exp.delete();
    rsp_exp.delete();
    ref_mem = ref_save;
    step(2);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_rsp_valid || lm_req_valid) seen++;
      step();
    end
    check("post_rst_quiet", 64'(seen), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_ready", 64'(bus.mem_req_ready), 64'd1);

    // RSP_DELAY=1 build: write then read addr 3
    bus2.mem_req_valid = 1'b1; bus2.mem_req_rw = 1'b1; bus2.mem_req_addr = 16'd3;
    bus2.mem_req_data = 32'h12345678; bus2.mem_req_byteen = 4'hF; bus2.mem_req_tag = 8'h00;
    check("fast_wr_ready", 64'(bus2.mem_req_ready), 64'd1);
    step();
    bus2.mem_req_valid = 1'b0;
    step(4);
    check("fast_idle", 64'(busy2), 64'd0);
    bus2.mem_req_valid = 1'b1; bus2.mem_req_rw = 1'b0; bus2.mem_req_tag = 8'h09;
    check("fast_rd_ready", 64'(bus2.mem_req_ready), 64'd1);
    acc = int'(cyc);
    step();
    bus2.mem_req_valid = 1'b0;
    seen = 0;
    while (!bus2.mem_rsp_valid && seen < 20) begin step(); seen++; end
    check("fast_rsp_seen", 64'(bus2.mem_rsp_valid), 64'd1);
    check("fast_latency", 64'(int'(cyc) - acc), 64'd4);
    check("fast_data", 64'(bus2.mem_rsp_data), 64'h12345678);
    check("fast_tag", 64'(bus2.mem_rsp_tag), 64'h09);
    check("fast_err", 64'(bus2.mem_rsp_err), 64'd0);
    step(2);

    // Random traffic with random response backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(1'($urandom_range(0, 1)), 16'($urandom_range(0, 71)), $urandom(),
           4'($urandom_range(0, 15)), 8'($urandom()), acc);
      step($urandom_range(0, 3));
    end
    wait_idle("rand_idle", 6000);
    rand_ready = 1'b0;
    step();
    bus.mem_rsp_ready = 1'b1;
    step(2);
    check("rand_rsp_drained", 64'(rsp_exp.size()), 64'd0);
    check("rand_lm_drained", 64'(lm_exp.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
